// File: rtl/bus_bridge_pkg.sv
// Shared constants for the CPU data-bus bridge: MMIO address map and 7-segment codes.
package bridge_pkg;

  localparam logic [31:0] IO_BASE      = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DIG     = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TMR_CNT = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TMR_DIV = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED     = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW      = 32'hFFFF_F070;

  // Active-low {dp,g,f,e,d,c,b,a}; entry [0] is digit 0, dp always off.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/bus_bridge_if.sv
// CPU data-bus handshake between the core's MEM stage (master) and the bridge (slave).
interface bus_bridge_if;
  logic [31:0] Bus_addr;
  logic        Bus_wen;
  logic [31:0] Bus_wdata;
  logic [31:0] Bus_rdata;

  modport master (output Bus_addr, output Bus_wen, output Bus_wdata, input Bus_rdata);
  modport slave  (input Bus_addr, input Bus_wen, input Bus_wdata, output Bus_rdata);
endinterface

// File: rtl/bus_bridge_seg7_scan.sv
// 8-digit multiplexed 7-segment scanner; one digit lit per SCAN_DIV cycles, registered outputs.
module seg7_scan
  import bridge_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 20000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic [31:0] digits,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      en_q, en_d;
  logic [7:0]      seg_q, seg_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_q == CntW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
    en_d  = ~(8'h01 << idx_q);
    seg_d = hex7seg(digits[{idx_q, 2'b00} +: 4]);
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      en_q  <= 8'hFE;
      seg_q <= 8'hC0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      en_q  <= en_d;
      seg_q <= seg_d;
    end
  end

  assign dig_en  = en_q;
  assign dig_seg = seg_q;

endmodule

// File: rtl/bus_bridge.sv
// Responder end of the CPU data bus: routes loads/stores to DRAM or MMIO
// (LED, switches, prescaled timer, 7-segment digit register).
module bus_bridge
  import bridge_pkg::*;
#(
  parameter int unsigned DRAM_AW       = 14,
  parameter int unsigned SCAN_DIV      = 20000,
  parameter logic [31:0] TIMER_DIV_RST = 32'd1000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  bus_bridge_if.slave        bus,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  logic        is_io;
  logic [23:0] led_q, led_d;
  logic [31:0] dig_q, dig_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_q, div_d;
  logic [31:0] pre_q, pre_d;
  logic [31:0] div_eff;
  logic        tick;
  logic [23:0] sw_meta_q, sw_sync_q;

  assign is_io      = (bus.Bus_addr >= IO_BASE);
  assign dram_addr  = bus.Bus_addr[DRAM_AW+1:2];
  assign dram_wen   = bus.Bus_wen & ~is_io;
  assign dram_wdata = bus.Bus_wdata;

  // A divisor of 0 behaves like 1: tick every cycle.
  assign div_eff = (div_q == 32'd0) ? 32'd1 : div_q;
  assign tick    = (pre_q >= div_eff - 32'd1);

  always_comb begin
    led_d = led_q;
    dig_d = dig_q;
    div_d = div_q;
    pre_d = tick ? 32'd0 : pre_q + 32'd1;
    cnt_d = tick ? cnt_q + 32'd1 : cnt_q;
    // Writes are applied after the tick so a count write overrides a coincident tick.
    if (bus.Bus_wen) begin
      case (bus.Bus_addr)
        ADDR_LED:     led_d = bus.Bus_wdata[23:0];
        ADDR_DIG:     dig_d = bus.Bus_wdata;
        ADDR_TMR_CNT: cnt_d = bus.Bus_wdata;
        ADDR_TMR_DIV: begin
          div_d = bus.Bus_wdata;
          pre_d = 32'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.Bus_rdata = 32'd0;
    if (!is_io) begin
      bus.Bus_rdata = dram_rdata;
    end else begin
      case (bus.Bus_addr)
        ADDR_DIG:     bus.Bus_rdata = dig_q;
        ADDR_TMR_CNT: bus.Bus_rdata = cnt_q;
        ADDR_TMR_DIV: bus.Bus_rdata = div_q;
        ADDR_LED:     bus.Bus_rdata = {8'd0, led_q};
        ADDR_SW:      bus.Bus_rdata = {8'd0, sw_sync_q};
        default:      bus.Bus_rdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rst) begin
      led_q     <= '0;
      dig_q     <= '0;
      cnt_q     <= '0;
      div_q     <= TIMER_DIV_RST;
      pre_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      dig_q     <= dig_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pre_q     <= pre_d;
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign led = led_q;

  seg7_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .digits (dig_q),
    .dig_en (dig_en),
    .dig_seg(dig_seg)
  );

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the register map.
module tb_bus_bridge;

  localparam int unsigned SCAN_DIV = 2;
  localparam logic [31:0] DIV_RST  = 32'd1000;
  localparam logic [31:0] A_DIG = 32'hFFFF_F000;
  localparam logic [31:0] A_CNT = 32'hFFFF_F020;
  localparam logic [31:0] A_DIV = 32'hFFFF_F024;
  localparam logic [31:0] A_LED = 32'hFFFF_F060;
  localparam logic [31:0] A_SW  = 32'hFFFF_F070;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  int checks = 0;
  int errors = 0;

  bus_bridge_if bus ();

  bus_bridge #(
    .DRAM_AW      (14),
    .SCAN_DIV     (SCAN_DIV),
    .TIMER_DIV_RST(DIV_RST)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rst   (cpu_rst),
    .bus       (bus),
    .dram_addr (dram_addr),
    .dram_wen  (dram_wen),
    .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata),
    .sw        (sw),
    .led       (led),
    .dig_en    (dig_en),
    .dig_seg   (dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Behavioural model state
  logic [23:0] m_led;
  logic [31:0] m_dig, m_cnt, m_div, m_pre, m_eff;
  logic [23:0] m_s1, m_s2;
  int unsigned m_cyc, m_idx;
  logic [7:0]  m_en, m_seg;

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  always @(posedge cpu_clk) begin : model
    if (!cpu_rst) begin
      m_led = '0; m_dig = '0; m_cnt = '0; m_div = DIV_RST; m_pre = '0;
      m_s1 = '0; m_s2 = '0; m_cyc = 0; m_en = 8'hFE; m_seg = 8'hC0;
    end else begin
      // Digit shown after this edge is the one selected by the elapsed cycle count before it.
      m_idx = (m_cyc / SCAN_DIV) % 8;
      m_en  = 8'hFF ^ (8'h01 << m_idx);
      m_seg = seg_of(4'((m_dig >> (4 * m_idx)) & 32'hF));
      m_cyc = m_cyc + 1;
      m_s2 = m_s1;
      m_s1 = sw;
      m_eff = (m_div == 32'd0) ? 32'd1 : m_div;
      if (m_pre >= m_eff - 32'd1) begin
        m_pre = 32'd0;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_pre = m_pre + 32'd1;
      end
      if (bus.Bus_wen) begin
        if (bus.Bus_addr == A_LED) m_led = bus.Bus_wdata[23:0];
        if (bus.Bus_addr == A_DIG) m_dig = bus.Bus_wdata;
        if (bus.Bus_addr == A_CNT) m_cnt = bus.Bus_wdata;
        if (bus.Bus_addr == A_DIV) begin
          m_div = bus.Bus_wdata;
          m_pre = 32'd0;
        end
      end
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a < 32'hFFFF_F000) return dram_rdata;
    if (a == A_DIG) return m_dig;
    if (a == A_CNT) return m_cnt;
    if (a == A_DIV) return m_div;
    if (a == A_LED) return {8'd0, m_led};
    if (a == A_SW)  return {8'd0, m_s2};
    return 32'd0;
  endfunction

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic set(input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.Bus_addr  = a;
    bus.Bus_wen   = w;
    bus.Bus_wdata = d;
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b0;
    set(A_LED, 1'b1, 32'hFFFF_FFFF);
    step();
    cpu_rst = 1'b1;
    set(A_LED, 1'b0, 32'd0);
    checks++;
    if (led !== 24'd0) begin
      errors++; $display("FAIL reset_led: got %h want 000000", led);
    end
    checks++;
    if (bus.Bus_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_led_rd: got %h want 0", bus.Bus_rdata);
    end
    checks++;
    if (dig_en !== 8'hFE || dig_seg !== 8'hC0) begin
      errors++; $display("FAIL reset_dig: got %h/%h want FE/C0", dig_en, dig_seg);
    end
    set(A_DIV, 1'b0, 32'd0);
    checks++;
    if (bus.Bus_rdata !== DIV_RST) begin
      errors++; $display("FAIL reset_div: got %h want %h", bus.Bus_rdata, DIV_RST);
    end
    set(A_CNT, 1'b0, 32'd0);
    checks++;
    if (bus.Bus_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %h want 0", bus.Bus_rdata);
    end
  endtask

  task automatic test_dram_led();
    dram_rdata = 32'hCAFE_0001;
    set(32'h0000_0010, 1'b1, 32'h1234_5678);
    checks++;
    if (dram_wen !== 1'b1 || dram_addr !== 14'd4 || dram_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL dram_store: got wen=%b addr=%h data=%h want 1/0004/12345678",
               dram_wen, dram_addr, dram_wdata);
    end
    step();
    set(32'h0000_0010, 1'b0, 32'd0);
    checks++;
    if (bus.Bus_rdata !== 32'hCAFE_0001) begin
      errors++; $display("FAIL dram_load: got %h want cafe0001", bus.Bus_rdata);
    end
    set(A_LED, 1'b1, 32'hFFA5_A5A5);
    checks++;
    if (dram_wen !== 1'b0) begin
      errors++; $display("FAIL io_no_dram_wen: got %b want 0", dram_wen);
    end
    step();
    set(A_LED, 1'b0, 32'd0);
    checks++;
    if (led !== 24'hA5A5A5) begin
      errors++; $display("FAIL led_write: got %h want a5a5a5", led);
    end
    checks++;
    if (bus.Bus_rdata !== 32'h00A5_A5A5) begin
      errors++; $display("FAIL led_read: got %h want 00a5a5a5", bus.Bus_rdata);
    end
    set(32'hFFFF_F050, 1'b1, 32'hDEAD_BEEF);
    checks++;
    if (bus.Bus_rdata !== 32'd0 || dram_wen !== 1'b0) begin
      errors++; $display("FAIL unmapped: got rd=%h wen=%b want 0/0", bus.Bus_rdata, dram_wen);
    end
    step();
    set(A_LED, 1'b0, 32'd0);
    checks++;
    if (bus.Bus_rdata !== 32'h00A5_A5A5) begin
      errors++; $display("FAIL unmapped_nowrite: got %h want 00a5a5a5", bus.Bus_rdata);
    end
  endtask

  task automatic test_sw_sync();
    sw = 24'd0;
    set(A_SW, 1'b0, 32'd0);
    step();
    step();
    sw = 24'h0F0F0F;
    step();
    checks++;
    if (bus.Bus_rdata !== 32'd0) begin
      errors++; $display("FAIL sw_sync_1edge: got %h want 0", bus.Bus_rdata);
    end
    step();
    checks++;
    if (bus.Bus_rdata !== 32'h000F_0F0F) begin
      errors++; $display("FAIL sw_sync_2edge: got %h want 000f0f0f", bus.Bus_rdata);
    end
  endtask

  task automatic test_timer();
    int n;
    set(A_DIV, 1'b1, 32'd4);
    step();
    set(A_CNT, 1'b1, 32'd0);
    step();
    set(A_CNT, 1'b0, 32'd0);
    repeat (12) step();
    checks++;
    if (bus.Bus_rdata !== 32'd3) begin
      errors++; $display("FAIL timer_count3: got %h want 3", bus.Bus_rdata);
    end
    set(A_CNT, 1'b1, 32'hFFFF_FFFF);
    step();
    set(A_CNT, 1'b0, 32'd0);
    n = 0;
    while (bus.Bus_rdata === 32'hFFFF_FFFF && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (bus.Bus_rdata !== 32'd0) begin
      errors++; $display("FAIL timer_wrap: got %h want 0", bus.Bus_rdata);
    end
    // Line up a count write with the edge where the model's prescaler expires.
    n = 0;
    while (m_pre != 32'd3 && n < 8) begin
      step();
      n++;
    end
    set(A_CNT, 1'b1, 32'd100);
    step();
    set(A_CNT, 1'b0, 32'd0);
    checks++;
    if (bus.Bus_rdata !== 32'd100) begin
      errors++; $display("FAIL timer_write_on_tick: got %0d want 100", bus.Bus_rdata);
    end
    repeat (4) step();
    checks++;
    if (bus.Bus_rdata !== 32'd101) begin
      errors++; $display("FAIL timer_after_tick: got %0d want 101", bus.Bus_rdata);
    end
  endtask

  task automatic test_scan();
    cpu_rst = 1'b0;
    set(A_LED, 1'b0, 32'd0);
    step();
    cpu_rst = 1'b1;
    set(A_DIG, 1'b1, 32'h0000_00A3);
    step();
    set(A_DIG, 1'b0, 32'd0);
    for (int i = 2; i < 34; i++) begin
      step();
      checks++;
      if (dig_en !== m_en || dig_seg !== m_seg) begin
        errors++;
        $display("FAIL scan_model[%0d]: got %h/%h want %h/%h", i, dig_en, dig_seg, m_en, m_seg);
      end
      if (i == 2 || i == 18) begin
        checks++;
        if (dig_en !== 8'hFE || dig_seg !== 8'hB0) begin
          errors++; $display("FAIL scan_d0[%0d]: got %h/%h want FE/B0", i, dig_en, dig_seg);
        end
      end
      if (i == 3 || i == 4) begin
        checks++;
        if (dig_en !== 8'hFD || dig_seg !== 8'h88) begin
          errors++; $display("FAIL scan_d1[%0d]: got %h/%h want FD/88", i, dig_en, dig_seg);
        end
      end
      if (i == 5) begin
        checks++;
        if (dig_en !== 8'hFB || dig_seg !== 8'hC0) begin
          errors++; $display("FAIL scan_d2: got %h/%h want FB/C0", dig_en, dig_seg);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, unm [4];
    logic        w;
    unm[0] = 32'hFFFF_F004; unm[1] = 32'hFFFF_F050;
    unm[2] = 32'hFFFF_FFFC; unm[3] = 32'hFFFF_F074;
    for (int i = 0; i < 300; i++) begin
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: begin a = $urandom; if (a >= 32'hFFFF_F000) a = a & 32'h7FFF_FFFF; end
        1: a = A_DIG;
        2: a = A_CNT;
        3: begin a = A_DIV; d = $urandom_range(0, 6); end
        4: a = A_LED;
        5: a = A_SW;
        6: a = unm[$urandom_range(0, 3)];
        default: a = 32'hFFFF_EFFC;
      endcase
      dram_rdata = $urandom;
      if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
      set(a, w, d);
      checks++;
      if (bus.Bus_rdata !== exp_rdata(a)) begin
        errors++;
        $display("FAIL rand_rdata[%0d] addr=%h: got %h want %h", i, a, bus.Bus_rdata,
                 exp_rdata(a));
      end
      checks++;
      if (dram_wen !== (w && a < 32'hFFFF_F000) || dram_addr !== a[15:2] || dram_wdata !== d)
      begin
        errors++;
        $display("FAIL rand_dram[%0d] addr=%h: got wen=%b addr=%h data=%h", i, a, dram_wen,
                 dram_addr, dram_wdata);
      end
      step();
      checks++;
      if (led !== m_led || dig_en !== m_en || dig_seg !== m_seg) begin
        errors++;
        $display("FAIL rand_outs[%0d]: got %h %h %h want %h %h %h", i, led, dig_en, dig_seg,
                 m_led, m_en, m_seg);
      end
    end
  endtask

  task automatic test_reset_midrun();
    set(A_DIV, 1'b1, 32'd2);
    step();
    set(A_LED, 1'b1, 32'h0012_3456);
    step();
    set(A_LED, 1'b0, 32'd0);
    repeat (9) step();
    cpu_rst = 1'b0;
    set(A_LED, 1'b1, 32'h00FF_FFFF);
    step();
    cpu_rst = 1'b1;
    set(A_LED, 1'b0, 32'd0);
    checks++;
    if (led !== 24'd0 || bus.Bus_rdata !== 32'd0) begin
      errors++; $display("FAIL midrst_led: got %h/%h want 0/0", led, bus.Bus_rdata);
    end
    checks++;
    if (dig_en !== 8'hFE || dig_seg !== 8'hC0) begin
      errors++; $display("FAIL midrst_dig: got %h/%h want FE/C0", dig_en, dig_seg);
    end
    set(A_CNT, 1'b0, 32'd0);
    checks++;
    if (bus.Bus_rdata !== 32'd0) begin
      errors++; $display("FAIL midrst_cnt: got %h want 0", bus.Bus_rdata);
    end
    set(A_DIV, 1'b0, 32'd0);
    checks++;
    if (bus.Bus_rdata !== DIV_RST) begin
      errors++; $display("FAIL midrst_div: got %h want %h", bus.Bus_rdata, DIV_RST);
    end
  endtask

  initial begin
    bus.Bus_addr  = 32'd0;
    bus.Bus_wen   = 1'b0;
    bus.Bus_wdata = 32'd0;
    dram_rdata    = 32'd0;
    sw            = 24'd0;
    repeat (2) step();
    test_reset();
    test_dram_led();
    test_sw_sync();
    test_timer();
    test_scan();
    test_random();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
